// File: rtl/addr_seq_unlock.sv
// Address-sequence unlock engine: matches an address nibble of each qualified
// window read against a key sequence, with failure lockout and scrambled read-back.
module addr_seq_unlock #(
  parameter int                          ADDR_W      = 14,
  parameter int                          WIN_W       = 2,
  parameter logic [WIN_W-1:0]            WIN         = 2'b01,
  parameter int                          NIB_LSB     = 4,
  parameter int                          NIB_W       = 4,
  parameter int                          KEY_LEN     = 4,
  parameter logic [KEY_LEN*NIB_W-1:0]    KEY         = 16'h9B95,
  parameter logic [NIB_W-1:0]            RELOCK_NIB  = 4'h0,
  parameter int                          MAX_FAIL    = 3,
  parameter int                          LOCKOUT_CYC = 16,
  parameter int                          LFSR_W      = 8,
  parameter logic [LFSR_W-1:0]           LFSR_TAPS   = 8'hB8,
  parameter logic [LFSR_W-1:0]           LFSR_SEED   = 8'h5A,
  parameter int                          RESP_W      = 2
) (
  input  logic                                                    clk,
  input  logic                                                    rst_n,
  input  logic [ADDR_W-1:0]                                       addr,
  input  logic                                                    sser_n,
  input  logic                                                    br_w,
  output logic [RESP_W-1:0]                                       resp_data,
  output logic                                                    resp_oe,
  output logic                                                    unlocked,
  output logic [1:0]                                              state_q,
  output logic [$clog2(KEY_LEN+1)-1:0]                            progress,
  output logic [((MAX_FAIL > 0) ? $clog2(MAX_FAIL+1) : 1)-1:0]    fail_cnt
);

  localparam int PROG_W = $clog2(KEY_LEN+1);
  localparam int FAIL_W = (MAX_FAIL > 0) ? $clog2(MAX_FAIL+1) : 1;
  localparam int LC_W   = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  localparam logic [FAIL_W-1:0] FAIL_SAT  = (MAX_FAIL > 0) ? FAIL_W'(MAX_FAIL) : {FAIL_W{1'b1}};
  localparam logic [NIB_W-1:0]  KEY_FIRST = KEY[NIB_W-1:0];

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } state_e;

  state_e              state, state_n;
  logic [PROG_W-1:0]   prog_n;
  logic [FAIL_W-1:0]   fail_n;
  logic [LC_W-1:0]     lock_cnt, lock_n;
  logic [LFSR_W-1:0]   lfsr, lfsr_n, lfsr_step;
  logic                qual, qual_d, evt;
  logic [NIB_W-1:0]    nib, key_cur;
  logic                unused_addr;

  assign qual        = ~sser_n & br_w & (addr[ADDR_W-1 -: WIN_W] == WIN);
  assign evt         = qual & ~qual_d;
  assign nib         = addr[NIB_LSB +: NIB_W];
  assign resp_oe     = qual;
  assign state_q     = state;
  assign unused_addr = ^addr;

  // Key entry selected by the current match position.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    key_cur = '0;
    for (int i = 0; i < KEY_LEN; i++) begin
      if (progress == PROG_W'(i)) key_cur = KEY[i*NIB_W +: NIB_W];
    end
  end

  // Galois-free Fibonacci step; an all-zero result would stick, so reseed.
  always_comb begin
    lfsr_step = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    if (lfsr_step == '0) lfsr_step = LFSR_SEED;
  end

  always_comb begin
    state_n = state;
    prog_n  = progress;
    fail_n  = fail_cnt;
    lock_n  = lock_cnt;
    lfsr_n  = lfsr;
    if (evt && state != LOCKOUT) lfsr_n = lfsr_step;

    unique case (state)
      HUNT: begin
        if (evt) begin
          if (nib == key_cur) begin
            if (progress == PROG_W'(KEY_LEN-1)) begin
              state_n = UNLOCKED;
              prog_n  = '0;
              fail_n  = '0;
            end else begin
              prog_n = progress + PROG_W'(1);
            end
          end else if (progress != '0) begin
            // A wrong nibble may itself be the start of a fresh attempt.
            prog_n = (nib == KEY_FIRST) ? PROG_W'(1) : '0;
            fail_n = (fail_cnt == FAIL_SAT) ? fail_cnt : fail_cnt + FAIL_W'(1);
            if (MAX_FAIL != 0 && fail_n == FAIL_SAT) begin
              state_n = LOCKOUT;
              lock_n  = LC_W'(LOCKOUT_CYC-1);
              prog_n  = '0;
            end
          end
        end
      end
      UNLOCKED: begin
        if (evt && nib == RELOCK_NIB) begin
          state_n = HUNT;
          prog_n  = '0;
        end
      end
      LOCKOUT: begin
        if (lock_cnt == '0) begin
          state_n = HUNT;
          fail_n  = '0;
        end else begin
          lock_n = lock_cnt - LC_W'(1);
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_comb begin
    resp_data = '0;
    unique case (state)
      HUNT:     resp_data = lfsr[RESP_W-1:0] ^ RESP_W'(progress);
      UNLOCKED: resp_data = lfsr[RESP_W-1:0];
      default:  resp_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= HUNT;
      progress <= '0;
      fail_cnt <= '0;
      lock_cnt <= '0;
      lfsr     <= LFSR_SEED;
      qual_d   <= 1'b0;
      unlocked <= 1'b0;
    end else begin
      state    <= state_n;
      progress <= prog_n;
      fail_cnt <= fail_n;
      lock_cnt <= lock_n;
      lfsr     <= lfsr_n;
      qual_d   <= qual;
      unlocked <= (state_n == UNLOCKED);
    end
  end

endmodule

// File: doc/addr_seq_unlock.md
Name: addr_seq_unlock

Overview:
- Parametrised synchronous address-sequence unlock engine for the bus-side security path.
- Monitors qualified read strobes into a decoded address window and compares a nibble of each access address against a programmable key sequence of KEY_LEN entries.
- Asserts an unlock flag on a full in-order match and applies a failure lockout.
- Returns LFSR-scrambled response bits to the data bus on every qualified window read.

Parameters:
ADDR_W, 14, bus address width
WIN_W, 2, number of top address bits used for window decode
WIN, 2'b01, value addr[ADDR_W-1 -: WIN_W] must equal
NIB_LSB, 4, LSB of key nibble within addr
NIB_W, 4, key nibble width
KEY_LEN, 4, key sequence length (2..16)
KEY, 16'h9B95, packed key, entry i at bits [i*NIB_W +: NIB_W]; default sequence 5,9,B,9
RELOCK_NIB, 4'h0, nibble that re-locks from UNLOCKED
MAX_FAIL, 3, failures before lockout (0 disables lockout)
LOCKOUT_CYC, 16, lockout duration in clk cycles
LFSR_W, 8, response LFSR width
LFSR_TAPS, 8'hB8, feedback tap mask
LFSR_SEED, 8'h5A, LFSR reset value (must be nonzero)
RESP_W, 2, response bits driven to bus

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr  in  ADDR_W  bus address
sser_n  in  1  bus select strobe, active low
br_w  in  1  1 = read, 0 = write
resp_data  out  RESP_W  response bits for data bus
resp_oe  out  1  drive enable for resp_data (external tristate)
unlocked  out  1  key sequence accepted
state_q  out  2  0 = HUNT, 1 = UNLOCKED, 2 = LOCKOUT
progress  out  clog2(KEY_LEN+1)  key entries matched so far
fail_cnt  out  clog2(MAX_FAIL+1)  consecutive failures

Behaviour:
- Reset is asynchronous and active-low. Reset values: state HUNT, progress 0, fail_cnt 0, lockout counter 0, lfsr LFSR_SEED, qual_d 0, unlocked 0.
- Qualification: qual = ~sser_n & br_w & (addr window == WIN), evaluated combinationally.
  - Event occurs when qual & ~qual_d, where qual_d is the registered qual.
  - A strobe held for N cycles is exactly one event.
- resp_oe = qual, combinational.
- resp_data = lfsr[RESP_W-1:0] ^ progress[RESP_W-1:0] in HUNT; lfsr[RESP_W-1:0] in UNLOCKED; 0 in LOCKOUT.
- LFSR:
  - On each event outside LOCKOUT: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)}.
  - If the result would be 0, load LFSR_SEED instead.
- Let nib = addr[NIB_LSB +: NIB_W]. All state updates take effect on the clk edge of the event cycle and are visible the next cycle.
- HUNT, on event:
  - Full match (nib == KEY[progress] and progress == KEY_LEN-1): go to UNLOCKED; progress 0; fail_cnt 0.
  - Partial match (nib == KEY[progress]): progress+1.
  - Mismatch with progress == 0: no change.
  - Mismatch with progress > 0: progress <= (nib == KEY[0]) ? 1 : 0; fail_cnt+1 (saturating).
    - If the new fail_cnt == MAX_FAIL and MAX_FAIL != 0: go to LOCKOUT; load lockout counter with LOCKOUT_CYC-1; progress 0.
- UNLOCKED:
  - unlocked = 1.
  - An event with nib == RELOCK_NIB returns to HUNT with progress 0.
  - Other events change only the LFSR.
- LOCKOUT:
  - Events are ignored and the LFSR is frozen.
  - The counter decrements every cycle. At 0, go to HUNT with fail_cnt 0.
- Writes (br_w=0), accesses outside the window, and sser_n high never advance any state.
- unlocked is registered (state == UNLOCKED); other outputs are decoded directly from registers.
- Reset asserted mid-sequence, in UNLOCKED, or in LOCKOUT returns all registers to reset values immediately, independent of clk.

Test Plan:
- Reset, then idle -> state_q=0, progress=0, unlocked=0, fail_cnt=0; resp_oe=0; after one qualified read with addr window mismatch on nibble, resp_data=SEED[1:0]^0=2'b10.
- Four qualified reads at addr 14'h1050, 14'h1090, 14'h10B0, 14'h1090 -> progress 1,2,3; unlocked=1 and state_q=1 the cycle after the 4th event.
- Same four addresses with br_w=0, or with addr[13:12]=2'b11 -> progress stays 0, unlocked=0, LFSR unchanged.
- sser_n held low 10 cycles at 14'h1050 -> progress=1 (single event), LFSR advanced once.
- Sequence 5,9,5 -> progress=1, fail_cnt=1. Three failing sequences -> state_q=2 for 16 cycles, resp_data=0, events ignored; then state_q=0, fail_cnt=0.
- Unlock, then read with nibble 0 -> state_q=0. Unlock again, pulse rst_n low mid-cycle -> unlocked=0 and lfsr=8'h5A without a clk edge.
